// File: rtl/fc_layer_sequencer_if.sv
// Handshake bundle between the fully-connected sequencer and its
// surroundings: CNN start flag, DMA engine, ALU and neuron buffers.
interface fc_layer_sequencer_if #(
  parameter int MEM_ADDRESS_WIDTH   = 16,
  parameter int LAYER_ADDRESS_WIDTH = 8
);
  logic                           start;
  logic                           dma_read;
  logic [MEM_ADDRESS_WIDTH-1:0]   dma_address;
  logic [LAYER_ADDRESS_WIDTH:0]   dma_count;
  logic                           dma_ready;
  logic                           alu_clear;
  logic                           alu_en;
  logic [1:0]                     alu_load;
  logic                           alu_valid;
  logic [2:0]                     bus_datasrc;
  logic                           neuron_wr;
  logic [1:0]                     neuron_layer;
  logic [LAYER_ADDRESS_WIDTH-1:0] neuron_address;
  logic                           busy;
  logic                           done;

  // The sequencer drives everything except the three inbound handshakes.
  modport master (
    input  start, dma_ready, alu_valid,
    output dma_read, dma_address, dma_count, alu_clear, alu_en, alu_load,
           bus_datasrc, neuron_wr, neuron_layer, neuron_address, busy, done
  );

  // Environment view: CNN stage, DMA engine, ALU and buffers.
  modport slave (
    output start, dma_ready, alu_valid,
    input  dma_read, dma_address, dma_count, alu_clear, alu_en, alu_load,
           bus_datasrc, neuron_wr, neuron_layer, neuron_address, busy, done
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Sequences up to four dense layers: loads each layer's input vector into
// the ALU, then per neuron fetches bias+weights over DMA, waits for the ALU
// result and writes the neuron into the layer's output buffer.
// Records for all layers sit back to back in memory, so one running address
// register that steps by the record length covers every layer.
module fc_layer_sequencer #(
  parameter int          MEM_ADDRESS_WIDTH   = 16,
  parameter int          LAYER_ADDRESS_WIDTH = 8,
  parameter int          NUM_LAYERS          = 2,
  parameter int          IN_SIZE             = 120,
  parameter logic [31:0] LAYER_SIZES         = {8'd0, 8'd0, 8'd10, 8'd84},
  parameter int          BASE_ADDR           = 0
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  clk_en,
  fc_layer_sequencer_if.master bus
);
  typedef logic [MEM_ADDRESS_WIDTH-1:0]   addr_t;
  typedef logic [LAYER_ADDRESS_WIDTH-1:0] idx_t;
  typedef logic [LAYER_ADDRESS_WIDTH:0]   cnt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_WAIT_DMA, S_WAIT_ALU, S_WRITE, S_DONE
  } state_t;

  localparam logic [1:0] ALU_VALUES  = 2'd0;
  localparam logic [1:0] ALU_WEIGHTS = 2'd1;
  localparam logic [1:0] ALU_HOLD    = 2'd2;
  localparam logic [2:0] SRC_DMA     = 3'd7;
  localparam logic [1:0] LAST_LAYER  = 2'(NUM_LAYERS - 1);

  state_t     state;
  logic [1:0] layer;
  idx_t       neuron;
  addr_t      addr;

  // Input-vector length of layer k: the CNN output for layer 0, otherwise
  // the size of the previous layer.
  function automatic cnt_t in_len(input logic [1:0] k);
    case (k)
      2'd0:    return cnt_t'(IN_SIZE);
      2'd1:    return cnt_t'(LAYER_SIZES[7:0]);
      2'd2:    return cnt_t'(LAYER_SIZES[15:8]);
      default: return cnt_t'(LAYER_SIZES[23:16]);
    endcase
  endfunction

  function automatic cnt_t layer_size(input logic [1:0] k);
    return cnt_t'(LAYER_SIZES[{k, 3'b000} +: 8]);
  endfunction

  // One record = bias word followed by one weight per input.
  cnt_t  rec_len;
  addr_t next_addr;
  logic  last_neuron;
  assign rec_len     = in_len(layer) + cnt_t'(1);
  assign next_addr   = addr + addr_t'(rec_len);
  assign last_neuron = (cnt_t'(neuron) == layer_size(layer) - cnt_t'(1));

  // Layer/neuron FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every register in
      // this block samples the pre-edge values, matching real flip-flops.
      state               <= S_IDLE;
      layer               <= '0;
      neuron              <= '0;
      addr                <= '0;
      bus.dma_read        <= 1'b0;
      bus.dma_address     <= '0;
      bus.dma_count       <= '0;
      bus.alu_clear       <= 1'b1;
      bus.alu_en          <= 1'b0;
      bus.alu_load        <= ALU_HOLD;
      bus.bus_datasrc     <= '0;
      bus.neuron_wr       <= 1'b0;
      bus.neuron_layer    <= '0;
      bus.neuron_address  <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
    end else if (clk_en) begin
      // Strobes and the DMA/write address fields are only meaningful in
      // their own state; everything else holds its last value.
      bus.dma_read       <= 1'b0;
      bus.dma_address    <= '0;
      bus.dma_count      <= '0;
      bus.neuron_wr      <= 1'b0;
      bus.neuron_layer   <= '0;
      bus.neuron_address <= '0;
      bus.done           <= 1'b0;
      bus.alu_en         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            layer           <= '0;
            neuron          <= '0;
            addr            <= addr_t'(BASE_ADDR);
            state           <= S_LOAD;
            bus.busy        <= 1'b1;
            bus.bus_datasrc <= 3'd0;
            bus.alu_load    <= ALU_VALUES;
            bus.alu_clear   <= 1'b0;
          end
        end
        S_LOAD: begin
          state           <= S_REQ;
          bus.dma_read    <= 1'b1;
          bus.dma_address <= addr;
          bus.dma_count   <= rec_len;
          bus.alu_clear   <= 1'b1;
          bus.alu_load    <= ALU_HOLD;
        end
        S_REQ: begin
          state <= S_WAIT_DMA;
        end
        S_WAIT_DMA: begin
          if (bus.dma_ready) begin
            state           <= S_WAIT_ALU;
            bus.bus_datasrc <= SRC_DMA;
            bus.alu_load    <= ALU_WEIGHTS;
            bus.alu_en      <= 1'b1;
            bus.alu_clear   <= 1'b0;
          end
        end
        S_WAIT_ALU: begin
          if (bus.alu_valid) begin
            state              <= S_WRITE;
            bus.neuron_wr      <= 1'b1;
            bus.neuron_layer   <= layer;
            bus.neuron_address <= neuron;
          end else begin
            bus.alu_en <= 1'b1;
          end
        end
        S_WRITE: begin
          // Stepping past the last record of a layer lands exactly on the
          // next layer's first record, so the address always advances.
          addr <= next_addr;
          if (!last_neuron) begin
            neuron          <= neuron + idx_t'(1);
            state           <= S_REQ;
            bus.dma_read    <= 1'b1;
            bus.dma_address <= next_addr;
            bus.dma_count   <= rec_len;
            bus.alu_clear   <= 1'b1;
            bus.alu_load    <= ALU_HOLD;
          end else if (layer != LAST_LAYER) begin
            layer           <= layer + 2'd1;
            neuron          <= '0;
            state           <= S_LOAD;
            bus.bus_datasrc <= {1'b0, layer + 2'd1};
            bus.alu_load    <= ALU_VALUES;
            bus.alu_clear   <= 1'b0;
          end else begin
            state           <= S_DONE;
            bus.done        <= 1'b1;
            bus.bus_datasrc <= 3'(NUM_LAYERS);
          end
        end
        S_DONE: begin
          state           <= S_IDLE;
          bus.busy        <= 1'b0;
          bus.bus_datasrc <= 3'd0;
          bus.alu_clear   <= 1'b1;
          bus.alu_load    <= ALU_HOLD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: stimulus pushes expected DMA
// records and neuron writes into queues; monitors pop and compare whenever
// the DUT presents a strobe.
module tb_fc_layer_sequencer;
  localparam int DMA_LAT = 7;
  localparam int ALU_LAT = 3;

  typedef struct { int addr; int cnt; } dma_t;
  typedef struct { int layer; int idx; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b1;
  always #5 clk = ~clk;

  fc_layer_sequencer_if #(.MEM_ADDRESS_WIDTH(16), .LAYER_ADDRESS_WIDTH(8)) dif ();
  fc_layer_sequencer_if #(.MEM_ADDRESS_WIDTH(16), .LAYER_ADDRESS_WIDTH(8)) dif2 ();

  fc_layer_sequencer dut (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(dif));

  fc_layer_sequencer #(
    .NUM_LAYERS(3), .IN_SIZE(4),
    .LAYER_SIZES({8'd0, 8'd2, 8'd3, 8'd5}), .BASE_ADDR(100)
  ) dut2 (.clk(clk), .rst(rst), .clk_en(1'b1), .bus(dif2));

  int total = 0;
  int bad = 0;

  dma_t q_dma[$];
  wr_t  q_wr[$];
  dma_t q2_dma[$];
  wr_t  q2_wr[$];

  int   cyc = 0;
  logic en_edge = 1'b1;
  logic rst_edge = 1'b0;

  int dma_n = 0, dma_hi_n = 0, wr_n = 0, done_n = 0, alu_en_n = 0, done_edge = 0;
  int done2_n = 0, done2_edge = 0;
  int log_base = 0;
  int log_addr [128];
  int log_cnt  [128];
  int last_addr = 0;
  bit busy_chk = 1'b0;
  int start_edge = 0, start2_edge = 0;

  bit   lat_mode = 1'b0, dma_lvl = 1'b0, alu_lvl = 1'b0;
  logic dma_lat_sig = 1'b0, alu_lat_sig = 1'b0;

  assign dif.dma_ready  = lat_mode ? dma_lat_sig : dma_lvl;
  assign dif.alu_valid  = lat_mode ? alu_lat_sig : alu_lvl;
  assign dif2.dma_ready = 1'b1;
  assign dif2.alu_valid = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Record whether the last edge actually advanced the DUT.
  always @(posedge clk) begin
    en_edge  <= clk_en;
    rst_edge <= rst;
    cyc      <= cyc + 1;
  end

  // Monitor for the default-parameter DUT.
  initial forever begin : mon1
    @(negedge clk);
    if (en_edge || !rst_edge) begin
      if (busy_chk) begin
        check("busy_after_done", dif.busy, 0);
        busy_chk = 1'b0;
      end
      if (dif.dma_read === 1'b1) begin
        dma_t e;
        dma_n++;
        dma_hi_n++;
        last_addr = int'(dif.dma_address);
        if (dma_n - log_base <= 128) begin
          log_addr[dma_n - log_base - 1] = int'(dif.dma_address);
          log_cnt[dma_n - log_base - 1]  = int'(dif.dma_count);
        end
        if (q_dma.size() == 0) check("dma_unexpected", 1, 0);
        else begin
          e = q_dma.pop_front();
          check("dma_address", dif.dma_address, e.addr);
          check("dma_count", dif.dma_count, e.cnt);
        end
      end
      if (dif.neuron_wr === 1'b1) begin
        wr_t w;
        wr_n++;
        if (q_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = q_wr.pop_front();
          check("neuron_layer", dif.neuron_layer, w.layer);
          check("neuron_address", dif.neuron_address, w.idx);
        end
      end
      if (dif.alu_en === 1'b1) alu_en_n++;
      if (dif.done === 1'b1) begin
        done_n++;
        done_edge = cyc;
        check("done_datasrc", dif.bus_datasrc, 2);
        busy_chk = 1'b1;
      end
    end else if (dif.dma_read === 1'b1) begin
      dma_hi_n++;
      check("dma_address_held", dif.dma_address, last_addr);
    end
  end

  // Monitor for the three-layer DUT.
  initial forever begin : mon2
    @(negedge clk);
    if (dif2.dma_read === 1'b1) begin
      dma_t e;
      if (q2_dma.size() == 0) check("dma2_unexpected", 1, 0);
      else begin
        e = q2_dma.pop_front();
        check("dma2_address", dif2.dma_address, e.addr);
        check("dma2_count", dif2.dma_count, e.cnt);
      end
    end
    if (dif2.neuron_wr === 1'b1) begin
      wr_t w;
      if (q2_wr.size() == 0) check("wr2_unexpected", 1, 0);
      else begin
        w = q2_wr.pop_front();
        check("neuron2_layer", dif2.neuron_layer, w.layer);
        check("neuron2_address", dif2.neuron_address, w.idx);
      end
    end
    if (dif2.done === 1'b1) begin
      done2_n++;
      done2_edge = cyc;
      check("done2_datasrc", dif2.bus_datasrc, 3);
    end
  end

  // DMA responder with fixed latency after the request cycle.
  initial forever begin : dma_resp
    step();
    if (lat_mode && dif.dma_read === 1'b1) begin
      repeat (DMA_LAT) @(negedge clk);
      dma_lat_sig = 1'b1;
      @(negedge clk);
      dma_lat_sig = 1'b0;
    end
  end

  // ALU responder: result ready ALU_LAT cycles after accumulation starts.
  initial forever begin : alu_resp
    step();
    if (lat_mode && dif.alu_en === 1'b1) begin
      repeat (ALU_LAT) @(negedge clk);
      alu_lat_sig = 1'b1;
      @(negedge clk);
      alu_lat_sig = 0;
    end
  end

  // Expected record stream for the default configuration (84 then 10 neurons).
  task automatic push_run();
    int sizes [2];
    int addr, in_len;
    sizes = '{84, 10};
    addr = 0;
    for (int k = 0; k < 2; k++) begin
      in_len = (k == 0) ? 120 : sizes[k-1];
      for (int n = 0; n < sizes[k]; n++) begin
        q_dma.push_back('{addr: addr, cnt: 1 + in_len});
        q_wr.push_back('{layer: k, idx: n});
        addr = (addr + 1 + in_len) % 65536;
      end
    end
  endtask

  task automatic pulse_start();
    dif.start  = 1'b1;
    start_edge = cyc + 1;
    step();
    dif.start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_n;
    n = 0;
    while (done_n == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_n == d0) check({name, "_timeout"}, 0, 1);
  endtask

  // Cycle count from the cycle start is sampled through the done cycle, inclusive.
  task automatic check_latency(input string name, input int exp);
    check(name, done_edge - start_edge + 2, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dma_read"}, dif.dma_read, 0);
    check({tag, "_dma_address"}, dif.dma_address, 0);
    check({tag, "_dma_count"}, dif.dma_count, 0);
    check({tag, "_alu_clear"}, dif.alu_clear, 1);
    check({tag, "_alu_en"}, dif.alu_en, 0);
    check({tag, "_alu_load"}, dif.alu_load, 2);
    check({tag, "_bus_datasrc"}, dif.bus_datasrc, 0);
    check({tag, "_neuron_wr"}, dif.neuron_wr, 0);
    check({tag, "_neuron_layer"}, dif.neuron_layer, 0);
    check({tag, "_neuron_address"}, dif.neuron_address, 0);
    check({tag, "_busy"}, dif.busy, 0);
    check({tag, "_done"}, dif.done, 0);
  endtask

  initial begin : main
    int e0, a0, hi0, w0, d0, found;
    int x2_addr [10];
    int x2_cnt  [10];
    int x2_lay  [10];
    int x2_idx  [10];

    dif.start  = 1'b0;
    dif2.start = 1'b0;
    repeat (3) step();
    check_idle("reset");
    rst = 1'b1;
    step();

    // Zero-latency responders.
    dma_lvl = 1'b1;
    alu_lvl = 1'b1;
    push_run();
    log_base = dma_n;
    e0 = dma_n; w0 = wr_n; a0 = alu_en_n;
    pulse_start();
    check("load_busy", dif.busy, 1);
    check("load_alu_load", dif.alu_load, 0);
    wait_done("run0", 1000);
    check_latency("run0_latency", 380);
    check("run0_dma_pulses", dma_n - e0, 94);
    check("run0_writes", wr_n - w0, 94);
    check("run0_alu_en_cycles", alu_en_n - a0, 94);
    check("rec0_addr", log_addr[0], 0);
    check("rec0_count", log_cnt[0], 121);
    check("rec83_addr", log_addr[83], 10043);
    check("rec84_addr", log_addr[84], 10164);
    check("rec84_count", log_cnt[84], 85);
    check("rec93_addr", log_addr[93], 10929);
    check("run0_queues_empty", q_dma.size() + q_wr.size(), 0);
    step();

    // DMA latency 7, ALU latency 3: 13 cycles per neuron, alu_en 4 cycles each.
    lat_mode = 1'b1;
    push_run();
    a0 = alu_en_n;
    pulse_start();
    wait_done("lat", 3000);
    check_latency("lat_latency", 1226);
    check("lat_alu_en_cycles", alu_en_n - a0, 376);
    lat_mode = 1'b0;
    step();

    // Reset while waiting on DMA for layer 1, neuron 5 (address 10164+5*85).
    push_run();
    pulse_start();
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      step();
      if (dif.dma_read === 1'b1 && dif.dma_address == 16'd10589) found = 1;
    end
    check("rst_target_found", found, 1);
    dma_lvl = 1'b0;
    step();
    check("rst_wait_busy", dif.busy, 1);
    q_dma.delete();
    q_wr.delete();
    rst = 1'b0;
    step();
    check_idle("midrun_reset");
    rst = 1'b1;
    dma_lvl = 1'b1;
    alu_lvl = 1'b1;
    w0 = wr_n;
    d0 = done_n;
    repeat (10) step();
    check("rst_no_writes", wr_n - w0, 0);
    check("rst_no_done", done_n - d0, 0);
    push_run();
    log_base = dma_n;
    pulse_start();
    wait_done("restart", 1000);
    check("restart_addr0", log_addr[0], 0);
    check("restart_queues_empty", q_dma.size() + q_wr.size(), 0);
    step();

    // clk_en low for three cycles during the first REQ.
    push_run();
    hi0 = dma_hi_n;
    pulse_start();
    found = 0;
    for (int i = 0; i < 5 && found == 0; i++) begin
      if (dif.dma_read === 1'b1) found = 1;
      else step();
    end
    check("stall_req_found", found, 1);
    clk_en = 1'b0;
    repeat (3) step();
    clk_en = 1'b1;
    wait_done("stall", 1000);
    check_latency("stall_latency", 383);
    check("stall_dma_high_cycles", dma_hi_n - hi0, 97);
    step();

    // start held high: one run, then the next begins right after IDLE.
    push_run();
    push_run();
    dif.start  = 1'b1;
    start_edge = cyc + 1;
    wait_done("held1", 1000);
    check_latency("held1_latency", 380);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (dif.dma_read === 1'b1) found = 1;
    end
    check("held_restart_gap", cyc - done_edge, 3);
    dif.start = 1'b0;
    wait_done("held2", 1000);
    repeat (5) step();
    check("held_idle_after", dif.busy, 0);
    check("held_queues_empty", q_dma.size() + q_wr.size(), 0);

    // Three-layer configuration: bases 100, 125, 143; counts 5, 6, 4.
    x2_addr = '{100, 105, 110, 115, 120, 125, 131, 137, 143, 147};
    x2_cnt  = '{5, 5, 5, 5, 5, 6, 6, 6, 4, 4};
    x2_lay  = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2};
    x2_idx  = '{0, 1, 2, 3, 4, 0, 1, 2, 0, 1};
    for (int i = 0; i < 10; i++) begin
      q2_dma.push_back('{addr: x2_addr[i], cnt: x2_cnt[i]});
      q2_wr.push_back('{layer: x2_lay[i], idx: x2_idx[i]});
    end
    d0 = done2_n;
    dif2.start  = 1'b1;
    start2_edge = cyc + 1;
    step();
    dif2.start  = 1'b0;
    for (int i = 0; i < 200 && done2_n == d0; i++) step();
    check("cfg2_done_seen", done2_n - d0, 1);
    check("cfg2_latency", done2_edge - start2_edge + 2, 45);
    check("cfg2_queues_empty", q2_dma.size() + q2_wr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
